// File: rtl/enokida_sa.sv
// enokida_sa: N-way set-associative, write-through, no-write-allocate data
// cache with a one-entry trace-driven prefetch slot.
// Both the processor side and the memory side use req/gnt/rvalid handshakes.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   proc_cache_data_*         processor side (req/addr/we/be/wdata in; gnt/rvalid/rdata out)
//   cache_mem_data_*          memory side (gnt/rvalid/rdata in; req/addr/we/be/wdata out)
//   trace_in, trace_ready     trace packet; the address field loads the prefetch slot
//   trace_capture_enable      allows a prefetch capture
//   lock                      freezes the counters and blocks prefetch capture
//   req/hit/miss/pf_count     32-bit statistics counters
module enokida_sa #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int WAYS           = 2,
  parameter int SETS           = 64,
  parameter int TRACE_ADDR_LSB = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    proc_cache_data_req_i,
  input  logic [ADDR_WIDTH-1:0]   proc_cache_data_addr_i,
  input  logic                    proc_cache_data_we_i,
  input  logic [DATA_WIDTH/8-1:0] proc_cache_data_be_i,
  input  logic [DATA_WIDTH-1:0]   proc_cache_data_wdata_i,
  output logic                    proc_cache_data_gnt_o,
  output logic                    proc_cache_data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   proc_cache_data_rdata_o,
  input  logic                    cache_mem_data_gnt_i,
  input  logic                    cache_mem_data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   cache_mem_data_rdata_i,
  output logic                    cache_mem_data_req_o,
  output logic [ADDR_WIDTH-1:0]   cache_mem_data_addr_o,
  output logic                    cache_mem_data_we_o,
  output logic [DATA_WIDTH/8-1:0] cache_mem_data_be_o,
  output logic [DATA_WIDTH-1:0]   cache_mem_data_wdata_o,
  input  logic [159:0]            trace_in,
  input  logic                    trace_ready,
  input  logic                    trace_capture_enable,
  input  logic                    lock,
  output logic [31:0]             req_count,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [31:0]             pf_count
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP, PF_LOOKUP, PF_REQ, PF_WAIT
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  we_reg;
  logic [BE_W-1:0]       be_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] resp_data_reg;
  logic                  pf_valid_reg;
  logic [ADDR_WIDTH-1:0] pf_addr_reg;
  logic [WAYS-1:0]       valid_reg [SETS];
  logic [WAY_W-1:0]      rr_reg    [SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_en;
  logic             proc_gnt;
  logic             pf_consume;
  logic             pf_capture;
  logic             fill_en;
  logic             merge_en;
  logic [WAYS-1:0]  hit_vec;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic             victim_from_rr;
  logic [WAYS-1:0][DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] hit_data;
  logic [DATA_WIDTH-1:0] merged_data;
  logic             unused_trace;

  assign idx        = addr_reg[OFF_W +: IDX_W];
  assign tag        = addr_reg[ADDR_WIDTH-1 -: TAG_W];
  assign proc_gnt   = (state_reg == IDLE) && proc_cache_data_req_i;
  assign pf_consume = (state_reg == IDLE) && !proc_cache_data_req_i && pf_valid_reg;
  assign pf_capture = trace_ready && trace_capture_enable && !lock;
  assign unused_trace = ^trace_in;

  // Tag/data arrays are read in IDLE so the registered read lines up with LOOKUP.
  assign rd_en  = (state_reg == IDLE);
  assign rd_idx = proc_cache_data_req_i ? proc_cache_data_addr_i[OFF_W +: IDX_W]
                                        : pf_addr_reg[OFF_W +: IDX_W];

  assign fill_en  = cache_mem_data_rvalid_i &&
                    (((state_reg == MEM_WAIT) && !we_reg) || (state_reg == PF_WAIT));
  assign merge_en = (state_reg == LOOKUP) && we_reg && hit;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]      tag_mem  [SETS];
      logic [DATA_WIDTH-1:0] data_mem [SETS];
      logic [TAG_W-1:0]      tag_rd_reg;
      logic [DATA_WIDTH-1:0] data_rd_reg;

      always_ff @(posedge clk) begin
        if (rd_en) begin
          tag_rd_reg  <= tag_mem[rd_idx];
          data_rd_reg <= data_mem[rd_idx];
        end
        if (fill_en && (victim_way == WAY_W'(gi))) begin
          tag_mem[idx]  <= tag;
          data_mem[idx] <= cache_mem_data_rdata_i;
        end else if (merge_en && (hit_way == WAY_W'(gi))) begin
          data_mem[idx] <= merged_data;
        end
      end

      assign rd_data[gi] = data_rd_reg;
      assign hit_vec[gi] = valid_reg[idx][gi] && (tag_rd_reg == tag);
    end

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
      assign merged_data[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8] : hit_data[8*gi +: 8];
    end
  endgenerate

  assign hit      = |hit_vec;
  assign hit_data = rd_data[hit_way];

  // Lowest-numbered hitting way; with a consistent tag store at most one hits.
  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  // Lowest invalid way wins; the round-robin pointer is only used on a full set.
  always_comb begin
    victim_way     = rr_reg[idx];
    victim_from_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_reg[idx][w]) begin
        victim_way     = WAY_W'(w);
        victim_from_rr = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (proc_cache_data_req_i) state_next = LOOKUP;
        else if (pf_valid_reg)     state_next = PF_LOOKUP;
      end
      LOOKUP:    state_next = (!we_reg && hit) ? IDLE : MEM_REQ;
      MEM_REQ:   if (cache_mem_data_gnt_i) state_next = MEM_WAIT;
      MEM_WAIT:  if (cache_mem_data_rvalid_i) state_next = RESP;
      RESP:      state_next = IDLE;
      PF_LOOKUP: state_next = hit ? IDLE : PF_REQ;
      PF_REQ:    if (cache_mem_data_gnt_i) state_next = PF_WAIT;
      PF_WAIT:   if (cache_mem_data_rvalid_i) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output logic; every output idles at 0 and gnt is forced low during reset.
  always_comb begin
    proc_cache_data_gnt_o    = proc_gnt && !rst;
    proc_cache_data_rvalid_o = 1'b0;
    proc_cache_data_rdata_o  = '0;
    cache_mem_data_req_o     = 1'b0;
    cache_mem_data_addr_o    = '0;
    cache_mem_data_we_o      = 1'b0;
    cache_mem_data_be_o      = '0;
    cache_mem_data_wdata_o   = '0;
    case (state_reg)
      LOOKUP: begin
        if (!we_reg && hit) begin
          proc_cache_data_rvalid_o = 1'b1;
          proc_cache_data_rdata_o  = hit_data;
        end
      end
      MEM_REQ: begin
        cache_mem_data_req_o   = 1'b1;
        cache_mem_data_addr_o  = addr_reg;
        cache_mem_data_we_o    = we_reg;
        cache_mem_data_be_o    = be_reg;
        cache_mem_data_wdata_o = we_reg ? wdata_reg : '0;
      end
      PF_REQ: begin
        cache_mem_data_req_o  = 1'b1;
        cache_mem_data_addr_o = addr_reg;
        cache_mem_data_be_o   = '1;
      end
      RESP: begin
        proc_cache_data_rvalid_o = 1'b1;
        proc_cache_data_rdata_o  = resp_data_reg;
      end
      default: ;
    endcase
  end

  // Datapath: request latch, prefetch slot, valid bits, replacement, counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      be_reg        <= '0;
      wdata_reg     <= '0;
      resp_data_reg <= '0;
      pf_valid_reg  <= 1'b0;
      pf_addr_reg   <= '0;
      req_count     <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      pf_count      <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        rr_reg[s]    <= '0;
      end
    end else begin
      if (proc_gnt) begin
        addr_reg  <= proc_cache_data_addr_i;
        we_reg    <= proc_cache_data_we_i;
        be_reg    <= proc_cache_data_be_i;
        wdata_reg <= proc_cache_data_wdata_i;
      end else if (pf_consume) begin
        addr_reg  <= pf_addr_reg;
        we_reg    <= 1'b0;
        be_reg    <= '1;
        wdata_reg <= '0;
      end

      // A capture in the consuming cycle leaves the new entry pending.
      if (pf_capture) begin
        pf_valid_reg <= 1'b1;
        pf_addr_reg  <= trace_in[TRACE_ADDR_LSB +: ADDR_WIDTH];
      end else if (pf_consume) begin
        pf_valid_reg <= 1'b0;
      end

      if ((state_reg == MEM_WAIT) && cache_mem_data_rvalid_i)
        resp_data_reg <= we_reg ? '0 : cache_mem_data_rdata_i;

      if (fill_en) begin
        valid_reg[idx][victim_way] <= 1'b1;
        if (victim_from_rr)
          rr_reg[idx] <= (rr_reg[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_reg[idx] + 1'b1;
      end

      if (!lock) begin
        if (proc_gnt) req_count <= req_count + 32'd1;
        if (state_reg == LOOKUP) begin
          if (hit) hit_count  <= hit_count + 32'd1;
          else     miss_count <= miss_count + 32'd1;
        end
        if (fill_en && (state_reg == PF_WAIT)) pf_count <= pf_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_enokida_sa.sv
module tb_enokida_sa;
  logic        clk = 1'b0;
  logic        rst;
  logic        proc_req, proc_we;
  logic [15:0] proc_addr;
  logic [3:0]  proc_be;
  logic [31:0] proc_wdata;
  logic        proc_gnt, proc_rvalid;
  logic [31:0] proc_rdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [159:0] trace_in;
  logic        trace_ready, trace_en, lock;
  logic [31:0] req_count, hit_count, miss_count, pf_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  enokida_sa dut (
    .clk(clk), .rst(rst),
    .proc_cache_data_req_i(proc_req), .proc_cache_data_addr_i(proc_addr),
    .proc_cache_data_we_i(proc_we), .proc_cache_data_be_i(proc_be),
    .proc_cache_data_wdata_i(proc_wdata), .proc_cache_data_gnt_o(proc_gnt),
    .proc_cache_data_rvalid_o(proc_rvalid), .proc_cache_data_rdata_o(proc_rdata),
    .cache_mem_data_gnt_i(mem_gnt), .cache_mem_data_rvalid_i(mem_rvalid),
    .cache_mem_data_rdata_i(mem_rdata), .cache_mem_data_req_o(mem_req),
    .cache_mem_data_addr_o(mem_addr), .cache_mem_data_we_o(mem_we),
    .cache_mem_data_be_o(mem_be), .cache_mem_data_wdata_o(mem_wdata),
    .trace_in(trace_in), .trace_ready(trace_ready),
    .trace_capture_enable(trace_en), .lock(lock),
    .req_count(req_count), .hit_count(hit_count),
    .miss_count(miss_count), .pf_count(pf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Present one request, check the combinational grant, end in LOOKUP.
  task automatic issue(input logic [15:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd);
    proc_req = 1'b1; proc_addr = a; proc_we = we; proc_be = be; proc_wdata = wd;
    #1;
    chk("gnt", {31'd0, proc_gnt}, 32'd1);
    step();
    proc_req = 1'b0; proc_addr = '0; proc_we = 1'b0; proc_be = '0; proc_wdata = '0;
  endtask

  // Memory side: wait for a request, check it, grant, reply rv_dly cycles later.
  task automatic mem_serve(input logic [15:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] rd, input int rv_dly);
    int n = 0;
    while (mem_req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("mem_req_seen", {31'd0, mem_req}, 32'd1);
    chk("mem_addr", {16'd0, mem_addr}, {16'd0, a});
    chk("mem_we", {31'd0, mem_we}, {31'd0, we});
    chk("mem_be", {28'd0, mem_be}, {28'd0, be});
    chk("mem_wdata", mem_wdata, wd);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
    repeat (rv_dly - 1) step();
    mem_rvalid = 1'b1; mem_rdata = rd;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic rd_hit(input logic [15:0] a, input logic [31:0] exp);
    issue(a, 1'b0, 4'hF, 32'd0);
    $display("read hit  addr=0x%04h rdata=0x%08h rvalid=%0d", a, proc_rdata, proc_rvalid);
    chk("hit_rvalid", {31'd0, proc_rvalid}, 32'd1);
    chk("hit_rdata", proc_rdata, exp);
    chk("hit_no_mem", {31'd0, mem_req}, 32'd0);
    step();
    chk("hit_rvalid_end", {31'd0, proc_rvalid}, 32'd0);
  endtask

  task automatic rd_miss(input logic [15:0] a, input logic [31:0] d);
    issue(a, 1'b0, 4'hF, 32'd0);
    chk("miss_no_early_rvalid", {31'd0, proc_rvalid}, 32'd0);
    mem_serve(a, 1'b0, 4'hF, 32'd0, d, 3);
    $display("read miss addr=0x%04h rdata=0x%08h rvalid=%0d", a, proc_rdata, proc_rvalid);
    chk("miss_rvalid", {31'd0, proc_rvalid}, 32'd1);
    chk("miss_rdata", proc_rdata, d);
    step();
    chk("miss_rvalid_end", {31'd0, proc_rvalid}, 32'd0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] wd);
    issue(a, 1'b1, be, wd);
    chk("wr_no_early_rvalid", {31'd0, proc_rvalid}, 32'd0);
    mem_serve(a, 1'b1, be, wd, 32'hFFFF_FFFF, 2);
    $display("write     addr=0x%04h be=%b wdata=0x%08h", a, be, wd);
    chk("wr_rvalid", {31'd0, proc_rvalid}, 32'd1);
    chk("wr_rdata_zero", proc_rdata, 32'd0);
    step();
  endtask

  task automatic counters(input string tag, input logic [31:0] r, input logic [31:0] h,
                          input logic [31:0] m, input logic [31:0] p);
    $display("counters %s req=%0d hit=%0d miss=%0d pf=%0d", tag, req_count, hit_count,
             miss_count, pf_count);
    chk({tag, "_req"}, req_count, r);
    chk({tag, "_hit"}, hit_count, h);
    chk({tag, "_miss"}, miss_count, m);
    chk({tag, "_pf"}, pf_count, p);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    proc_req = 0; proc_we = 0; proc_addr = '0; proc_be = '0; proc_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    trace_in = '0; trace_ready = 0; trace_en = 1'b1; lock = 0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_rvalid", {31'd0, proc_rvalid}, 32'd0);
    chk("rst_rdata", proc_rdata, 32'd0);
    counters("rst", 0, 0, 0, 0);

    // Cold read then repeat
    rd_miss(16'h0040, 32'hDEADBEEF);
    counters("cold", 1, 0, 1, 0);
    rd_hit(16'h0040, 32'hDEADBEEF);
    counters("warm", 2, 1, 1, 0);

    // Three tags into set 0: the third evicts way 0 (0x0000)
    do_reset();
    rd_miss(16'h0000, 32'hA0A0_0000);
    rd_miss(16'h0100, 32'hA1A1_0100);
    rd_miss(16'h0200, 32'hA2A2_0200);
    rd_miss(16'h0000, 32'hB0B0_0000);
    counters("conflict", 4, 0, 4, 0);
    rd_hit(16'h0200, 32'hA2A2_0200);
    counters("conflict_hit", 5, 1, 4, 0);

    // Write hit merges byte 1 only
    do_reset();
    rd_miss(16'h0080, 32'h11223344);
    wr(16'h0080, 4'b0010, 32'h0000AB00);
    rd_hit(16'h0080, 32'h1122AB44);
    counters("wrhit", 3, 2, 1, 0);

    // Write miss does not allocate
    do_reset();
    wr(16'h0300, 4'hF, 32'h5555AAAA);
    rd_miss(16'h0300, 32'hCAFEF00D);
    counters("wrmiss", 2, 0, 2, 0);

    // Prefetch from trace
    do_reset();
    trace_in = '0;
    trace_in[47:32] = 16'h0500;
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    trace_in = '0;
    mem_serve(16'h0500, 1'b0, 4'hF, 32'd0, 32'h0BADF00D, 2);
    $display("prefetch  addr=0x0500 rvalid=%0d", proc_rvalid);
    chk("pf_no_rvalid", {31'd0, proc_rvalid}, 32'd0);
    step();
    chk("pf_no_rvalid2", {31'd0, proc_rvalid}, 32'd0);
    counters("pf", 0, 0, 0, 1);
    rd_hit(16'h0500, 32'h0BADF00D);
    counters("pf_hit", 1, 1, 0, 1);

    // Lock: counters frozen, trace ignored
    lock = 1'b1;
    trace_in[47:32] = 16'h0600;
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    trace_in = '0;
    repeat (3) rd_hit(16'h0500, 32'h0BADF00D);
    lock = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_req === 1'b1) seen++;
    end
    chk("lock_no_pf", seen, 0);
    counters("lock", 1, 1, 0, 1);

    // Reset in MEM_WAIT abandons the miss
    issue(16'h0700, 1'b0, 4'hF, 32'd0);
    seen = 0;
    while (mem_req !== 1'b1 && seen < 50) begin
      step();
      seen++;
    end
    chk("rstmid_mem_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    proc_req = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    $display("reset in MEM_WAIT gnt=%0d rvalid=%0d mem_req=%0d", proc_gnt, proc_rvalid, mem_req);
    chk("rstmid_gnt", {31'd0, proc_gnt}, 32'd0);
    chk("rstmid_rvalid", {31'd0, proc_rvalid}, 32'd0);
    chk("rstmid_mem_req_low", {31'd0, mem_req}, 32'd0);
    chk("rstmid_req_count", req_count, 32'd0);
    proc_req = 1'b0;
    step();
    rst = 1'b0;
    rd_miss(16'h0700, 32'h77770700);
    counters("after_rst", 1, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/enokida_sa.md
Name: enokida_sa

Overview:
- Parametrised N-way set-associative successor to the direct-mapped trace-assisted data cache.
- Sits between the RI5CY LSU data port and data memory. Both sides use the RI5CY req/gnt/rvalid protocol.
- Adds configurable ways and sets, per-set round-robin replacement, and a one-entry trace-driven prefetch slot.
- Exposes request, hit, miss and prefetch counters.

Parameters:
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 32, word width; one word per line
WAYS, 2, associativity; power of 2, range 1..8
SETS, 64, sets per way; power of 2
TRACE_ADDR_LSB, 32, LSB of the data-address field inside trace_in

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
proc_cache_data_req_i  in  1  processor request
proc_cache_data_addr_i  in  ADDR_WIDTH  byte address
proc_cache_data_we_i  in  1  write enable
proc_cache_data_be_i  in  DATA_WIDTH/8  byte enables
proc_cache_data_wdata_i  in  DATA_WIDTH  write data
proc_cache_data_gnt_o  out  1  request granted
proc_cache_data_rvalid_o  out  1  response valid
proc_cache_data_rdata_o  out  DATA_WIDTH  read data
cache_mem_data_gnt_i  in  1  memory grant
cache_mem_data_rvalid_i  in  1  memory response valid
cache_mem_data_rdata_i  in  DATA_WIDTH  memory read data
cache_mem_data_req_o  out  1  memory request
cache_mem_data_addr_o  out  ADDR_WIDTH  memory address
cache_mem_data_we_o  out  1  memory write enable
cache_mem_data_be_o  out  DATA_WIDTH/8  memory byte enables
cache_mem_data_wdata_o  out  DATA_WIDTH  memory write data
trace_in  in  160  trace packet; address field at [TRACE_ADDR_LSB+ADDR_WIDTH-1:TRACE_ADDR_LSB]
trace_ready  in  1  trace packet valid
trace_capture_enable  in  1  allows prefetch capture
lock  in  1  freezes counters and blocks prefetch capture
req_count, hit_count, miss_count, pf_count  out  32 each  statistics

Behaviour:
- Reset: asynchronous and active-high. Clears all valid bits, round-robin pointers, prefetch slot, counters and all outputs to 0, and returns the FSM to IDLE. Reset asserted mid-transaction abandons the transaction; no response is produced.
- Address split: offset = log2(DATA_WIDTH/8) bits, index = log2(SETS) bits, tag = remainder.
- FSM states: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP, PF_LOOKUP, PF_REQ, PF_WAIT.
- IDLE:
  - gnt_o = req_i combinationally; the granted address, we, be and wdata are latched; next state LOOKUP.
  - If no req_i and the prefetch slot is valid: consume the slot and go to PF_LOOKUP.
  - A processor request always wins over the prefetch slot.
- LOOKUP, read hit: rvalid_o=1 with rdata from the hit way. rvalid therefore arrives 1 cycle after gnt. Next state IDLE.
- LOOKUP, read miss: next state MEM_REQ with we=0.
- LOOKUP, write, hit or miss: write-through.
  - On a hit, merge the enabled bytes into the hit way.
  - No allocate on a miss.
  - Next state MEM_REQ with we=1, be and wdata passed through.
- MEM_REQ: cache_mem_data_req_o held at 1 with stable address, we, be and wdata until gnt_i; then MEM_WAIT.
- MEM_WAIT: wait for rvalid_i.
  - On a read, fill the victim way with rdata_i, set the line valid and write the tag.
  - Victim = lowest-numbered invalid way, else the set's round-robin pointer. The pointer increments modulo WAYS only on a fill that used it.
  - Next state RESP.
- RESP: rvalid_o=1. rdata_o = filled data on a read, 0 on a write. Next state IDLE.
- Prefetch slot capture:
  - Loaded when trace_ready & trace_capture_enable & !lock.
  - A new capture overwrites a pending entry.
  - Capture in the same cycle the slot is consumed: the new entry stays valid.
- PF_LOOKUP: on a hit, drop the entry and go to IDLE. On a miss, go to PF_REQ, then PF_WAIT, fill as for a read miss, then IDLE with no proc rvalid.
- Processor requests arriving while a prefetch is in flight are not granted until the FSM is back in IDLE.
- Counters (all skip updates while lock=1, and wrap at 2^32):
  - req_count: +1 per processor gnt.
  - hit_count: +1 per LOOKUP hit, read or write.
  - miss_count: +1 per LOOKUP miss.
  - pf_count: +1 per prefetch fill.
- Outputs are 0 whenever not actively driven. This includes mem addr/we/be/wdata outside MEM_REQ and PF_REQ.
- WAYS=1 must behave as a direct-mapped cache.

Test Plan:
- Cold read: read addr 0x0040, mem returns 0xDEADBEEF 3 cycles after gnt -> one mem read at 0x0040, proc rvalid with 0xDEADBEEF, miss_count=1. Repeat the read -> rvalid 1 cycle after gnt with no mem req, hit_count=1, req_count=2.
- Conflict, WAYS=2, SETS=64: read 0x0000, 0x0100, 0x0200 (same set) then re-read 0x0000 -> 0x0200 evicts the way holding 0x0000. The final read of 0x0000 misses; miss_count=4.
- Write hit with be=4'b0010, wdata 0x0000AB00 on a line holding 0x11223344 -> mem write issued with be 0010. A subsequent read hit returns 0x1122AB44.
- Write miss to 0x0300, then read 0x0300 -> the write causes no fill; the read misses; miss_count=2.
- Prefetch: trace_in with address field 0x0500 while idle, enable=1, lock=0 -> PF mem read at 0x0500, pf_count=1, no proc rvalid. A later read of 0x0500 hits.
- Lock and reset:
  - lock=1 during three hit reads -> counters unchanged, trace packet ignored.
  - Assert rst during MEM_WAIT -> all outputs 0 immediately; the following read of the same address misses.
